iddr_deserializer: RTL and testbench

IDDR_DESERIALIZER -- requirements
Module: iddr_deserializer

---
 rtl/iddr_deserializer_pkg.sv | 13 +
 rtl/iddr_capture.sv | 35 +++
 rtl/iddr_deserializer.sv | 118 +++++++++++
 tb/tb_iddr_deserializer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iddr_deserializer_pkg.sv
// Shared definitions for the IDDR deserializer: defaults and FSM state encoding.
package iddr_deserializer_pkg;

  localparam int unsigned DefWidth = 8;
  localparam logic [7:0]  DefSync  = 8'hA5;

  // Alignment FSM: hunting for the sync word, or locked onto a word boundary.
  typedef enum logic {
    StHunt   = 1'b0,
    StLocked = 1'b1
  } state_e;

endpackage

// File: rtl/iddr_capture.sv
// Input DDR capture: falling-edge sample retimed so both bits of a pair update on the rising edge.
module iddr_capture #(
  parameter logic INIT = 1'b0
) (
  input  logic C,
  input  logic CLR,
  input  logic CE,
  input  logic D,
  output logic Q0,
  output logic Q1
);

  logic fall_s;

  // Falling-edge sample, taken regardless of CE.
  always_ff @(negedge C or posedge CLR) begin
    if (CLR) begin
      fall_s <= INIT;
    end else begin
      fall_s <= D;
    end
  end

  // Rising-edge pair register: Q1 holds the earlier (falling-edge) bit, Q0 the later one.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      Q0 <= INIT;
      Q1 <= INIT;
    end else if (CE) begin
      Q0 <= D;
      Q1 <= fall_s;
    end
  end

endmodule

// File: rtl/iddr_deserializer.sv
// DDR deserializer: shifts bit pairs into a window, hunts for the sync word at either bit
// offset, then emits one aligned word every WIDTH/2 enabled cycles.
module iddr_deserializer
  import iddr_deserializer_pkg::*;
#(
  parameter int unsigned      WIDTH = DefWidth,
  parameter logic [WIDTH-1:0] SYNC  = WIDTH'(DefSync),
  parameter logic             INIT  = 1'b0
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             CE,
  input  logic             D,
  input  logic             RESYNC,
  output logic             Q0,
  output logic             Q1,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID,
  output logic             LOCKED,
  output logic             PHASE
);

  localparam int unsigned     CntW   = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH / 2 - 1);

  state_e           state_q, state_d;
  logic [WIDTH:0]   win_q, win_d;
  logic [WIDTH:0]   win_next;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             phase_q, phase_d;
  logic             match_even, match_odd, wrap;

  iddr_capture #(
    .INIT (INIT)
  ) u_capture (
    .C   (C),
    .CLR (CLR),
    .CE  (CE),
    .D   (D),
    .Q0  (Q0),
    .Q1  (Q1)
  );

  // Lock and word extraction look at the window as it will be after this edge's shift,
  // so the first data word starts exactly on the pair following the sync word.
  assign win_next   = {win_q[WIDTH-2:0], Q1, Q0};
  assign match_even = (win_next[WIDTH-1:0] == SYNC);
  assign match_odd  = (win_next[WIDTH:1] == SYNC);
  assign wrap       = (cnt_q == CntMax);

  // Next-state: RESYNC overrides everything; otherwise advance only on enabled edges.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    phase_d  = phase_q;
    if (RESYNC) begin
      state_d = StHunt;
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (CE) begin
      win_d = win_next;
      unique case (state_q)
        StHunt: begin
          // Even offset wins when both alignments match.
          if (match_even) begin
            state_d = StLocked;
            phase_d = 1'b0;
            cnt_d   = '0;
          end else if (match_odd) begin
            state_d = StLocked;
            phase_d = 1'b1;
            cnt_d   = '0;
          end
        end
        StLocked: begin
          if (wrap) begin
            cnt_d    = '0;
            dvalid_d = 1'b1;
            dout_d   = phase_q ? win_next[WIDTH:1] : win_next[WIDTH-1:0];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // State, window, counter and output registers.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q  <= StHunt;
      win_q    <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      phase_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      phase_q  <= phase_d;
    end
  end

  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;
  assign LOCKED = (state_q == StLocked);
  assign PHASE  = phase_q;

endmodule

// File: tb/tb_iddr_deserializer.sv
// Scoreboard bench for iddr_deserializer: a bit-stream reference model predicts words,
// a monitor compares every cycle.
module tb_iddr_deserializer;

  localparam logic [7:0] SyncWord = 8'hA5;

  logic       C = 1'b0;
  logic       CLR, CE, D, RESYNC;
  logic       Q0, Q1, DVALID, LOCKED, PHASE;
  logic [7:0] DOUT;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: captured bit stream (oldest first), pending pair, lock status.
  bit         stream_q[$];
  logic [7:0] word_q[$];
  logic [7:0] seen_q[$];
  logic [1:0] m_pend;
  bit         m_locked, m_phase, m_fire;
  int         m_pairs;
  bit         done = 1'b0;

  always #5 C = ~C;

  iddr_deserializer dut (
    .C      (C),
    .CLR    (CLR),
    .CE     (CE),
    .D      (D),
    .RESYNC (RESYNC),
    .Q0     (Q0),
    .Q1     (Q1),
    .DOUT   (DOUT),
    .DVALID (DVALID),
    .LOCKED (LOCKED),
    .PHASE  (PHASE)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    stream_q.delete();
    for (int i = 0; i < 9; i++) stream_q.push_back(1'b0);
    word_q.delete();
    m_pend   = 2'b00;
    m_locked = 1'b0;
    m_phase  = 1'b0;
    m_fire   = 1'b0;
    m_pairs  = 0;
  endtask

  // One rising edge of the reference: a pair accepted on an enabled edge joins the stream
  // on the next enabled edge; every 4 pairs after the sync word form one word.
  task automatic model_edge(input bit a, input bit b);
    logic [7:0] w0, w1;
    int n;
    m_fire = 1'b0;
    if (CLR) return;
    if (RESYNC) begin
      m_locked = 1'b0;
      m_phase  = 1'b0;
      m_pairs  = 0;
      if (CE) m_pend = {a, b};
      return;
    end
    if (!CE) return;
    stream_q.push_back(m_pend[1]);
    stream_q.push_back(m_pend[0]);
    n = stream_q.size();
    for (int i = 0; i < 8; i++) begin
      w0[7-i] = stream_q[n-8+i];
      w1[7-i] = stream_q[n-9+i];
    end
    if (!m_locked) begin
      if (w0 == SyncWord) begin
        m_locked = 1'b1;
        m_phase  = 1'b0;
        m_pairs  = 0;
      end else if (w1 == SyncWord) begin
        m_locked = 1'b1;
        m_phase  = 1'b1;
        m_pairs  = 0;
      end
    end else begin
      m_pairs++;
      if (m_pairs == 4) begin
        m_pairs = 0;
        m_fire  = 1'b1;
        word_q.push_back(m_phase ? w1 : w0);
      end
    end
    m_pend = {a, b};
    while (stream_q.size() > 32) void'(stream_q.pop_front());
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin : monitor
    logic [7:0] last;
    logic [7:0] exp;
    last = '0;
    while (!done) begin
      @(posedge C);
      #1;
      if (CLR) last = '0;
      check("dvalid", DVALID, m_fire);
      if (m_fire) begin
        exp = word_q.pop_front();
        if (DVALID) begin
          check("dout_word", DOUT, exp);
          seen_q.push_back(DOUT);
        end
        last = exp;
      end else begin
        check("dout_hold", DOUT, last);
      end
      check("locked", LOCKED, m_locked);
      check("phase", PHASE, m_phase);
      check("q0", Q0, m_pend[0]);
      check("q1", Q1, m_pend[1]);
    end
  end

  // Drivers start and end each call at rising edge + 2.
  task automatic send_pair(input bit a, input bit b, input bit ce = 1'b1, input bit rs = 1'b0);
    D      = a;
    CE     = ce;
    RESYNC = rs;
    @(negedge C);
    #2 D = b;
    @(posedge C);
    model_edge(a, b);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 4; i++) send_pair(v[7-2*i], v[6-2*i]);
  endtask

  task automatic send_bits(input logic [63:0] v, input int nbits);
    for (int i = nbits - 1; i > 0; i -= 2) send_pair(v[i], v[i-1]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_pair(1'b0, 1'b0);
  endtask

  // Asynchronous clear mid-cycle: outputs must drop at once, before any clock edge.
  task automatic do_clr();
    #1 CLR = 1'b1;
    #1;
    check("clr_q0", Q0, 1'b0);
    check("clr_q1", Q1, 1'b0);
    check("clr_dout", DOUT, 8'h00);
    check("clr_dvalid", DVALID, 1'b0);
    check("clr_locked", LOCKED, 1'b0);
    check("clr_phase", PHASE, 1'b0);
    model_reset();
    seen_q.delete();
    @(posedge C);
    #2 CLR = 1'b0;
  endtask

  initial begin : stim
    CLR    = 1'b1;
    CE     = 1'b0;
    D      = 1'b0;
    RESYNC = 1'b0;
    model_reset();
    @(posedge C);
    #2 CLR = 1'b0;

    // Even lock: A5 then 3C.
    idle(3);
    send_byte(SyncWord);
    send_byte(8'h3C);
    idle(5);
    check("even_first_word", seen_q.size() > 0 ? seen_q[0] : 8'hxx, 8'h3C);
    check("even_phase", PHASE, 1'b0);

    // Clear mid-word, then odd lock: one pad bit before A5.
    send_pair(1'b1, 1'b1);
    do_clr();
    check("clr_relock_needed", LOCKED, 1'b0);
    idle(2);
    send_bits({40'h0, 1'b0, 8'hA5, 8'h3C, 7'h00}, 24);
    idle(2);
    check("odd_first_word", seen_q.size() > 0 ? seen_q[0] : 8'hxx, 8'h3C);
    check("odd_phase", PHASE, 1'b1);

    // CE low for three pairs in the middle of 3C.
    do_clr();
    idle(2);
    send_byte(SyncWord);
    send_pair(1'b0, 1'b0);
    send_pair(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) send_pair(1'b1, 1'b0, 1'b0);
    send_pair(1'b1, 1'b1);
    send_pair(1'b0, 1'b0);
    idle(2);
    check("ce_gap_word", seen_q.size() > 0 ? seen_q[0] : 8'hxx, 8'h3C);

    // RESYNC on the wrap edge of 55 suppresses it; A5 again re-locks.
    do_clr();
    idle(2);
    send_byte(SyncWord);
    send_byte(8'h55);
    send_pair(1'b0, 1'b0, 1'b1, 1'b1);
    check("resync_unlocked", LOCKED, 1'b0);
    idle(4);
    send_byte(SyncWord);
    send_byte(8'h42);
    idle(2);
    check("resync_first_word", seen_q.size() > 0 ? seen_q[0] : 8'hxx, 8'h42);

    // Back-to-back words, sync pattern passed through as data.
    do_clr();
    idle(2);
    send_byte(SyncWord);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(SyncWord);
    idle(2);
    check("b2b_count", seen_q.size() >= 4, 1'b1);
    if (seen_q.size() >= 4) begin
      check("b2b_w0", seen_q[0], 8'h01);
      check("b2b_w1", seen_q[1], 8'h02);
      check("b2b_w2", seen_q[2], 8'h03);
      check("b2b_w3", seen_q[3], SyncWord);
    end

    // Randomised traffic with sync words, CE gaps, resyncs and occasional clears.
    do_clr();
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        send_byte(SyncWord);
      end else if ($urandom_range(0, 199) == 0) begin
        do_clr();
      end else begin
        send_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) != 0, $urandom_range(0, 59) == 0);
      end
    end
    idle(3);
    done = 1'b1;
    @(posedge C);
    #3;
    check("queue_drained", word_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
